// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: byte-addressed core port to word-addressed data memory.
// Splits word-crossing accesses into two beats and extends load data.
module dmem_lsu_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter bit          ALLOW_MISALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [2:0]            mem_op_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [7:0]            sh_q, sh_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           hi_q, hi_d;

    logic       accept;
    logic [3:0] mask_in;
    logic [7:0] sh_in;
    logic       cross_in;
    logic       cross_q;
    logic [5:0] lo_shamt;
    logic [5:0] hi_shamt;
    logic [31:0] merged;
    logic [31:0] ext;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign accept   = req_valid && (state_q == IDLE);
    assign mask_in  = (req_size == 2'd0) ? 4'h1 : (req_size == 2'd1) ? 4'h3 : 4'hF;
    assign sh_in    = {4'b0, mask_in} << req_addr[1:0];
    assign cross_in = |sh_in[7:4];
    assign cross_q  = |sh_q[7:4];
    assign lo_shamt = {1'b0, off_q, 3'b000};
    assign hi_shamt = 6'd32 - lo_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (cross_in && !ALLOW_MISALIGN) ? RESP : BEAT1;
            BEAT1:   state_d = cross_q ? BEAT2 : RESP;
            BEAT2:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            sh_q    <= '0;
            wa_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            sh_q    <= sh_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        sh_d    = sh_q;
        wa_d    = wa_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (accept) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            off_d   = req_addr[1:0];
            sh_d    = sh_in;
            wa_d    = req_addr[ADDR_WIDTH+1:2];
            wdata_d = req_wdata;
            err_d   = cross_in && !ALLOW_MISALIGN;
        end
        if (state_q == BEAT1) lo_d = mem_rdata;
        if (state_q == BEAT2) hi_d = mem_rdata;
    end

    // Crossing implies off != 0, so hi_shamt never reaches 32 when the hi term is used.
    always_comb begin
        merged = (lo_q >> lo_shamt) | (cross_q ? (hi_q << hi_shamt) : 32'h0);
        case (size_q)
            2'd0:    ext = {{24{merged[7] & ~uns_q}}, merged[7:0]};
            2'd1:    ext = {{16{merged[15] & ~uns_q}}, merged[15:0]};
            default: ext = merged;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        mem_we      = 1'b0;
        mem_be      = '0;
        mem_op_read = 3'b010;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            BEAT1: begin
                mem_we    = we_q;
                mem_be    = sh_q[3:0];
                mem_addr  = wa_q;
                mem_wdata = wdata_q << lo_shamt;
            end
            BEAT2: begin
                mem_we    = we_q;
                mem_be    = sh_q[7:4];
                mem_addr  = wa_q + ADDR_WIDTH'(1);
                mem_wdata = wdata_q >> hi_shamt;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'h0 : ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Randomised and directed bench for dmem_lsu_ctrl against a byte-array memory model.
// A second instance with misaligned splitting disabled checks rejection.
module tb_dmem_lsu_ctrl;

    localparam int AW = 15;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [2:0]    mem_op_read;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    logic          n_valid, n_ready, n_we, n_unsigned;
    logic [1:0]    n_size;
    logic [31:0]   n_addr, n_wdata;
    logic          n_resp_valid, n_resp_err;
    logic [31:0]   n_resp_rdata;
    logic          n_mem_we;
    logic [3:0]    n_mem_be;
    logic [2:0]    n_op_unused;
    logic [AW-1:0] n_mem_addr;
    logic [31:0]   n_mem_wdata, n_mem_rdata;

    logic [31:0]   tb_mem [0:(1<<AW)-1];
    logic [7:0]    ref_b  [0:(1<<(AW+2))-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    int            nm_act_cnt;
    int            checks, fails;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic          we;
    } beat_t;
    beat_t beats[$];

    dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .ALLOW_MISALIGN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we), .mem_be(mem_be),
        .mem_op_read(mem_op_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .ALLOW_MISALIGN(1'b0)) u_nm (
        .clk(clk), .rst_n(rst_n), .req_valid(n_valid), .req_ready(n_ready),
        .req_we(n_we), .req_size(n_size), .req_unsigned(n_unsigned),
        .req_addr(n_addr), .req_wdata(n_wdata), .resp_valid(n_resp_valid),
        .resp_rdata(n_resp_rdata), .resp_err(n_resp_err), .mem_we(n_mem_we), .mem_be(n_mem_be),
        .mem_op_read(n_op_unused), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_rdata(n_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata   = tb_mem[mem_addr];
    assign n_mem_rdata = tb_mem[n_mem_addr];

    always @(posedge clk) begin
        if (bd_we) tb_mem[bd_addr] <= bd_data;
        else if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    always @(posedge clk)
        if (n_mem_we || n_mem_be != 4'h0 || n_mem_wdata != 32'h0) nm_act_cnt <= nm_act_cnt + 1;

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, logic uns);
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[int'((a + 32'(i)) & 32'h1FFFF)];
        if (sz == 2'd0 && !uns) v[31:8]  = {24{v[7]}};
        if (sz == 2'd1 && !uns) v[31:16] = {16{v[15]}};
        return v;
    endfunction

    function automatic logic [31:0] ref_word(int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    function automatic bit crosses(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'd1 && a[1:0] == 2'd3) || (sz[1] && a[1:0] != 2'd0);
    endfunction

    task automatic ref_store(logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_b[int'((a + 32'(i)) & 32'h1FFFF)] = d[8*i +: 8];
    endtask

    task automatic bd_write(int w, logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = AW'(w); bd_data = d;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
        @(posedge clk); #1 bd_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        beats.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
            if (mem_we || mem_be != 4'h0)
                beats.push_back('{a: mem_addr, be: mem_be, wd: mem_wdata, we: mem_we});
        end while (!resp_valid && lat < 10);
        checks++;
        if (!resp_valid) begin
            fails++; $display("FAIL resp_timeout: got no resp_valid, required one within 10 cycles");
        end
        rd = resp_rdata; er = resp_err;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL resp_pulse: got resp_valid=%b req_ready=%b, required 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic nm_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        n_valid = 1'b1; n_we = we; n_size = sz; n_unsigned = 1'b0; n_addr = a; n_wdata = wd;
        @(posedge clk); #1 n_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!n_resp_valid && lat < 10);
        rd = n_resp_rdata; er = n_resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, {AW{1'b0}}, 32'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b we=%b be=%h a=%h wd=%h, required 1/0/0/0/0/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_be, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_op_read !== 3'b010) begin
            fails++; $display("FAIL mem_op_read: got %b, required 010", mem_op_read);
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        ref_store(32'h10, 2'd2, 32'hDEADBEEF);
        checks++;
        if (beats.size() != 1 || beats[0].a !== AW'(4) || beats[0].be !== 4'hF ||
            beats[0].wd !== 32'hDEADBEEF || beats[0].we !== 1'b1 || lat != 2 || rd !== 32'h0) begin
            fails++;
            $display("FAIL sw_beat: got n=%0d a=%h be=%h wd=%h lat=%0d rd=%h, required 1/4/F/DEADBEEF/2/0",
                     beats.size(), beats[0].a, beats[0].be, beats[0].wd, lat, rd);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || lat != 2 || beats.size() != 1 || beats[0].a !== AW'(4) ||
            beats[0].be !== 4'hF || beats[0].we !== 1'b0) begin
            fails++;
            $display("FAIL lw_aligned: got rd=%h lat=%0d n=%0d, required DEADBEEF/2/1", rd, lat, beats.size());
        end
    endtask

    task automatic test_load_extend;
        logic [31:0] rd; logic er; int lat;
        logic [31:0] exp_v [4] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h000080F1};
        bd_write(0, 32'h000080F1);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'(i / 2), 1'(i % 2), 32'h0, 32'h0, rd, er, lat);
            checks++;
            if (rd !== exp_v[i]) begin
                fails++; $display("FAIL load_extend_%0d: got %h, required %h", i, rd, exp_v[i]);
            end
        end
    endtask

    task automatic test_split_store;
        logic [31:0] rd; logic er; int lat;
        bd_write(1, 32'h0); bd_write(2, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h7, 32'h0000A5C3, rd, er, lat);
        ref_store(32'h7, 2'd1, 32'h0000A5C3);
        checks++;
        if (beats.size() != 2 || beats[0].a !== AW'(1) || beats[0].be !== 4'h8 ||
            beats[0].wd[31:24] !== 8'hC3 || beats[1].a !== AW'(2) || beats[1].be !== 4'h1 ||
            beats[1].wd[7:0] !== 8'hA5 || lat != 3) begin
            fails++;
            $display("FAIL sh_split: got n=%0d b0=%h/%h/%h b1=%h/%h/%h lat=%0d, required 2 1/8/C3xxxxxx 2/1/xxxxxxA5 3",
                     beats.size(), beats[0].a, beats[0].be, beats[0].wd, beats[1].a, beats[1].be, beats[1].wd, lat);
        end
        checks++;
        if (tb_mem[1] !== ref_word(1) || tb_mem[2] !== ref_word(2)) begin
            fails++;
            $display("FAIL sh_split_mem: got %h %h, required %h %h", tb_mem[1], tb_mem[2], ref_word(1), ref_word(2));
        end
    endtask

    task automatic test_split_load;
        logic [31:0] rd; logic er; int lat; int act0;
        bd_write(0, 32'h44332211); bd_write(1, 32'h88776655);
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h66554433 || er !== 1'b0 || lat != 3) begin
            fails++; $display("FAIL lw_split: got rd=%h err=%b lat=%0d, required 66554433/0/3", rd, er, lat);
        end
        nm_req(1'b0, 2'd2, 32'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h44332211 || er !== 1'b0 || lat != 2) begin
            fails++; $display("FAIL nm_aligned: got rd=%h err=%b lat=%0d, required 44332211/0/2", rd, er, lat);
        end
        act0 = nm_act_cnt;
        nm_req(1'b0, 2'd2, 32'h2, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1 || lat != 1) begin
            fails++; $display("FAIL nm_reject_ld: got rd=%h err=%b lat=%0d, required 0/1/1", rd, er, lat);
        end
        nm_req(1'b1, 2'd1, 32'h3, 32'hFFFF, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1 || nm_act_cnt != act0) begin
            fails++;
            $display("FAIL nm_reject_st: got rd=%h err=%b mem_cycles=%0d, required 0/1/0", rd, er, nm_act_cnt - act0);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er; int lat;
        bd_write((1 << AW) - 1, 32'hDDCCBBAA);
        do_req(1'b0, 2'd2, 1'b0, 32'h1FFFD, 32'h0, rd, er, lat);
        checks++;
        if (rd !== ref_load(32'h1FFFD, 2'd2, 1'b0) || beats.size() != 2 ||
            beats[0].a !== AW'((1 << AW) - 1) || beats[1].a !== AW'(0)) begin
            fails++;
            $display("FAIL wrap: got rd=%h n=%0d a0=%h a1=%h, required %h/2/7fff/0",
                     rd, beats.size(), beats[0].a, beats[1].a, ref_load(32'h1FFFD, 2'd2, 1'b0));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, exp_rd; logic er; int lat; logic we, uns; logic [1:0] sz;
        for (int w = 0; w < 16; w++) bd_write(w, $urandom);
        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 59)); wd = $urandom;
            exp_rd = we ? 32'h0 : ref_load(a, sz, uns);
            if (we) ref_store(a, sz, wd);
            do_req(we, sz, uns, a, wd, rd, er, lat);
            checks++;
            if (rd !== exp_rd || er !== 1'b0 || lat != (crosses(a, sz) ? 3 : 2)) begin
                fails++;
                $display("FAIL rand_%0d: we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d, required %h/0/%0d",
                         k, we, sz, a, rd, er, lat, exp_rd, crosses(a, sz) ? 3 : 2);
            end
        end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (tb_mem[w] !== ref_word(w)) begin
                fails++; $display("FAIL rand_mem_%0d: got %h, required %h", w, tb_mem[w], ref_word(w));
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4;
        for (int c = 0; c < 8; c++) begin
            if (req_ready) acc.push_back(c);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc.size() < 2 || acc[1] - acc[0] != 3) begin
            fails++; $display("FAIL back_to_back: got %0d accepts, spacing %0d, required spacing 3",
                              acc.size(), acc.size() > 1 ? acc[1] - acc[0] : 0);
        end
    endtask

    task automatic test_reset_mid;
        bd_write(1, 32'h11111111); bd_write(2, 32'h22222222);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h7; req_wdata = 32'h0000BEEF;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
            fails++; $display("FAIL reset_mid: got rdy=%b we=%b be=%h, required 1/0/0", req_ready, mem_we, mem_be);
        end
        ref_b[7] = 8'hEF;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tb_mem[1] !== ref_word(1) || tb_mem[2] !== ref_word(2)) begin
            fails++;
            $display("FAIL reset_mid_mem: got %h %h, required %h %h", tb_mem[1], tb_mem[2], ref_word(1), ref_word(2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0; fails = 0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        n_valid = 1'b0; n_we = 1'b0; n_size = '0; n_unsigned = 1'b0; n_addr = '0; n_wdata = '0;
        test_reset();
        test_word_store_load();
        test_load_extend();
        test_split_store();
        test_split_load();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
